// File: rtl/div_top_1_pkg.sv
// Shared constants for the pipelined restoring divider.
//   DW_DEF : default dividend / quotient width
//   VW_DEF : default divisor / remainder width
package div_top_1_pkg;
  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;
endpackage

// File: rtl/div_top_1_if.sv
// Operand / result bundle of the divider.
//   en, dividend, divisor                        : operand side (master drives)
//   quotient, remainder, div_zero, result_rdy    : result side (slave drives)
interface div_top_1_if
  import div_top_1_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
);
  logic          en;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  logic          result_rdy;

  modport master (
    output en, dividend, divisor,
    input  quotient, remainder, div_zero, result_rdy
  );

  modport slave (
    input  en, dividend, divisor,
    output quotient, remainder, div_zero, result_rdy
  );
endinterface

// File: rtl/div_cell_1.sv
// One restoring-division stage: resolves one quotient bit per clock.
//   clk, rst          : clock, synchronous active-high reset
//   src_vld/dst_vld   : stage valid in / out
//   src_rem/dst_rem   : partial remainder in / out
//   src_dq/dst_dq     : dividend bits still to consume (MSB side) with the
//                       quotient bits already resolved shifted in at the LSB
//   src_dsr/dst_dsr   : divisor, travels with the data
//   src_dz/dst_dz     : divide-by-zero flag, travels with the data
module div_cell_1
  import div_top_1_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_vld,
  input  logic [VW-1:0] src_rem,
  input  logic [DW-1:0] src_dq,
  input  logic [VW-1:0] src_dsr,
  input  logic          src_dz,
  output logic          dst_vld,
  output logic [VW-1:0] dst_rem,
  output logic [DW-1:0] dst_dq,
  output logic [VW-1:0] dst_dsr,
  output logic          dst_dz
);
  logic [VW:0]   trial;
  logic [VW-1:0] diff;
  logic          take;

  // Trial remainder is VW+1 bits wide so the compare is exact.
  assign trial = {src_rem, src_dq[DW-1]};
  assign take  = (trial >= {1'b0, src_dsr});
  // When take=1 the true difference is < divisor, so the VW-bit wrap-around
  // subtract gives the exact value. Only the low VW bits of the partial
  // remainder are ever consumed downstream, so VW bits are stored.
  assign diff  = trial[VW-1:0] - src_dsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_vld <= 1'b0;
      dst_rem <= '0;
      dst_dq  <= '0;
      dst_dsr <= '0;
      dst_dz  <= 1'b0;
    end else begin
      dst_vld <= src_vld;
      dst_rem <= take ? diff : trial[VW-1:0];
      // Dividend leaves at the MSB while the new quotient bit enters at the LSB;
      // after DW stages the register holds the full quotient.
      dst_dq  <= {src_dq[DW-2:0], take};
      dst_dsr <= src_dsr;
      dst_dz  <= src_dz;
    end
  end
endmodule

// File: rtl/div_top_1.sv
// Pipelined unsigned restoring divider, one operation accepted per clock.
// Latency: operands sampled at edge N -> result_rdy and results at edge N+DW.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : div_top_1_if slave (en/dividend/divisor in,
//               quotient/remainder/div_zero/result_rdy out)
module div_top_1
  import div_top_1_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic    clk,
  input  logic    rst,
  div_top_1_if.slave bus
);
  logic [DW:0]          vld_pipe;
  logic [DW:0][VW-1:0]  rem_pipe;
  logic [DW:0][DW-1:0]  dq_pipe;
  logic [DW:0][VW-1:0]  dsr_pipe;
  logic [DW:0]          dz_pipe;
  logic [VW-1:0]        unused_dsr_tail;

  // Stage-0 feed straight from the operand port; zero detect happens here.
  assign vld_pipe[0] = bus.en;
  assign rem_pipe[0] = '0;
  assign dq_pipe[0]  = bus.dividend;
  assign dsr_pipe[0] = bus.divisor;
  assign dz_pipe[0]  = (bus.divisor == '0);

  // The divisor leaving the last stage has no consumer.
  assign unused_dsr_tail = dsr_pipe[DW];

  for (genvar k = 0; k < DW; k++) begin : g_stage
    div_cell_1 #(.DW(DW), .VW(VW)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .src_vld (vld_pipe[k]),
      .src_rem (rem_pipe[k]),
      .src_dq  (dq_pipe[k]),
      .src_dsr (dsr_pipe[k]),
      .src_dz  (dz_pipe[k]),
      .dst_vld (vld_pipe[k+1]),
      .dst_rem (rem_pipe[k+1]),
      .dst_dq  (dq_pipe[k+1]),
      .dst_dsr (dsr_pipe[k+1]),
      .dst_dz  (dz_pipe[k+1])
    );
  end

  // Output registers hold the last result between strobes. With a zero
  // divisor every stage takes the subtract-zero path, so the remainder
  // already equals dividend[VW-1:0]; the quotient is forced to all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result_rdy <= 1'b0;
      bus.quotient   <= '0;
      bus.remainder  <= '0;
      bus.div_zero   <= 1'b0;
    end else begin
      bus.result_rdy <= vld_pipe[DW];
      if (vld_pipe[DW]) begin
        bus.quotient  <= dz_pipe[DW] ? {DW{1'b1}} : dq_pipe[DW];
        bus.remainder <= rem_pipe[DW];
        bus.div_zero  <= dz_pipe[DW];
      end
    end
  end
endmodule

// File: tb/tb_div_top_1.sv
module tb_div_top_1;
  localparam int DW = 16;
  localparam int VW = 8;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  exp_t sb[$];

  div_top_1_if #(.DW(DW), .VW(VW)) bus ();

  div_top_1 #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one operand for exactly one sampling edge; expected result queued.
  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       input logic [DW-1:0] q, input logic [VW-1:0] r, input logic dz);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz; e.cyc = cyc + 1 + DW;
    bus.en = 1'b1; bus.dividend = a; bus.divisor = b;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.en = 1'b0;
  endtask

  task automatic issue_model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    if (b == '0) issue(a, b, {DW{1'b1}}, a[VW-1:0], 1'b1);
    else         issue(a, b, DW'(a / DW'(b)), VW'(a % DW'(b)), 1'b0);
  endtask

  task automatic idle(input int n);
    bus.en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 4*DW) begin @(posedge clk); n++; end
    #1;
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rdy"}, bus.result_rdy, 0);
    chk({tag, "_q"},   bus.quotient, 0);
    chk({tag, "_r"},   bus.remainder, 0);
    chk({tag, "_dz"},  bus.div_zero, 0);
  endtask

  // Monitor: every result strobe is matched against the scoreboard head.
  always @(negedge clk) begin
    if (bus.result_rdy) begin
      if (sb.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_rdy: got result_rdy=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        logic [31:0] inv;
        e = sb.pop_front();
        chk("quotient",  bus.quotient,  e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_zero",  bus.div_zero,  e.dz);
        chk("latency",   cyc,           e.cyc);
        if (!e.dz) begin
          inv = 32'(bus.quotient) * 32'(e.b) + 32'(bus.remainder);
          chk("invariant",  inv, 32'(e.a));
          chk("rem_lt_div", 32'(bus.remainder < e.b), 1);
        end
      end
    end
  end

  initial begin
    bus.en = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors
    issue(16'd1000,  8'd7,   16'd142,   8'd6,   1'b0);
    idle(DW + 2);
    issue(16'd65535, 8'd255, 16'd257,   8'd0,   1'b0);
    issue(16'd0,     8'd5,   16'd0,     8'd0,   1'b0);
    issue(16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0);
    issue(16'd5,     8'd200, 16'd0,     8'd5,   1'b0);
    idle(2);
    issue(16'd100,   8'd0,   16'hFFFF,  8'h64,  1'b1);
    issue(16'd100,   8'd3,   16'd33,    8'd1,   1'b0);
    drain();

    // Throughput: 20 back-to-back operations
    for (int i = 0; i < 20; i++)
      issue_model(DW'($urandom), VW'($urandom_range(1, 255)));
    idle(3);
    drain();

    // Reset mid-flight: 5 ops, then rst sampled on the 8th edge
    for (int i = 0; i < 5; i++) issue_model(DW'(1000 + i), VW'(3 + i));
    idle(2);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk_outputs_zero("midrst");
    idle(DW + 4);
    chk("midrst_none", sb.size(), 0);
    issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    drain();

    // Random regression with gaps and zero divisors
    for (int i = 0; i < 10000; i++) begin
      logic [VW-1:0] b;
      b = ($urandom_range(0, 15) == 0) ? '0 : VW'($urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      issue_model(DW'($urandom), b);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
